// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register IDs, default depths, load codes.
// Used by decode, writeback and the hazard unit.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int DEF_WB_DEPTH      = 3;
  localparam int DEF_SQUASH_CYCLES = 2;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_H    = 3'd2,
    LD_W    = 3'd3,
    LD_BU   = 3'd4,
    LD_HU   = 3'd5
  } ld_code_t;

  function automatic logic reg_hit(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  used,
    input logic [REG_ADDR_W-1:0] dst
  );
    return used && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination shift register mirroring decode->writeback,
// with source comparators producing the RAW hazard flag.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH = DEF_WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [REG_ADDR_W-1:0] dst_in,
  input  logic [REG_ADDR_W-1:0] a0,
  input  logic [REG_ADDR_W-1:0] a1,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic                  raw
);

  logic [REG_ADDR_W-1:0] sb [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        sb[i] <= REG_ZERO;
    end else if (shift_en) begin
      sb[0] <= dst_in;
      for (int i = 1; i < DEPTH; i++)
        sb[i] <= sb[i-1];
    end
  end

  // Duplicates are legal; any matching slot hazards.
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      raw = raw
          | reg_hit(a0, rs1_used, sb[i])
          | reg_hit(a1, rs2_used, sb[i]);
  end

endmodule

// File: rtl/hazard_control.sv
// Stall/squash/hold control for decode and fetch.
// Optional perf counters enabled by HAZARD_PERF_CNT_EN.
module hazard_control
  import pipe_pkg::*;
#(
  parameter int WB_DEPTH      = DEF_WB_DEPTH,
  parameter int SQUASH_CYCLES = DEF_SQUASH_CYCLES,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] a0,
  input  logic [REG_ADDR_W-1:0] a1,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] a2_hazard,
  input  logic                  jmp_taken,
  input  logic                  mem_busy,
  output logic                  stall,
  output logic                  hold_fetch,
  output logic                  squash
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      raw_bubble_cnt,
  output logic [CNT_W-1:0]      jmp_bubble_cnt
`endif
);

  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES - 1);

  logic [2:0] sq_cnt;
  logic       raw;
  logic       jmp_active;
  logic [REG_ADDR_W-1:0] dst_in;

  assign stall      = mem_busy & rst;
  assign jmp_active = (jmp_taken & ~stall) | (sq_cnt != 3'd0);
  assign squash     = jmp_active | raw | ~rst;
  assign hold_fetch = raw & ~jmp_active & rst;
  assign dst_in     = squash ? REG_ZERO : a2_hazard;

  hazard_scoreboard #(
    .DEPTH (WB_DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .shift_en (~stall),
    .dst_in   (dst_in),
    .a0       (a0),
    .a1       (a1),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .raw      (raw)
  );

  // A jump during a squash window restarts the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_cnt <= 3'd0;
    end else if (!stall) begin
      if (jmp_taken)
        sq_cnt <= SQ_LOAD;
      else if (sq_cnt != 3'd0)
        sq_cnt <= sq_cnt - 3'd1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_bubble_cnt <= '0;
      jmp_bubble_cnt <= '0;
    end else if (!stall) begin
      if (raw && !jmp_active && !(&raw_bubble_cnt))
        raw_bubble_cnt <= raw_bubble_cnt + 1'b1;
      if (jmp_active && !(&jmp_bubble_cnt))
        jmp_bubble_cnt <= jmp_bubble_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Pipeline hazard and control-flow unit. It produces the `stall`/`squash` controls consumed by the decode stage and by fetch.
- It consumes the decode stage's source register IDs (`a0`, `a1`) and its squash-gated destination ID (`a2_hazard`).
- It tracks in-flight destinations in a scoreboard that mirrors the decode→writeback latch chain.
- It inserts RAW bubbles, squashes wrong-path instructions on a taken jump, and freezes the pipeline on memory busy.

Parameters:
- `WB_DEPTH`, 3: stages between decode output and register-file write; this is the scoreboard depth.
- `SQUASH_CYCLES`, 2: bubble cycles inserted after a taken jump (fetch + decode wrong-path slots), valid range 1..7.
- `CNT_W`, 32: width of the performance counters (optional feature only).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `a0`  in  5  decode rs1 ID.
- `a1`  in  5  decode rs2 ID.
- `rs1_used`  in  1  decode instruction reads `a0`.
- `rs2_used`  in  1  decode instruction reads `a1`.
- `a2_hazard`  in  5  decode destination ID, already squash-gated; 0 = no write.
- `jmp_taken`  in  1  execute stage resolved a taken jump/branch this cycle.
- `mem_busy`  in  1  memory stage cannot complete this cycle.
- `stall`  out  1  global freeze of all pipeline latches.
- `hold_fetch`  out  1  PC/fetch register holds its value.
- `squash`  out  1  decode stage loads a bubble.

Behaviour:
- **Scoreboard.** `sb[0..WB_DEPTH-1]`, 5 bits each.
  - When `stall`=0: `sb[0]` ← (`squash` ? 0 : `a2_hazard`), and `sb[i]` ← `sb[i-1]`.
  - When `stall`=1: all entries hold.
- **RAW detect** (combinational):
  - `raw` = (`rs1_used` & `a0`≠0 & `a0` matches any `sb[i]`) | (`rs2_used` & `a1`≠0 & `a1` matches any `sb[i]`).
  - x0 never hazards.
- **Squash counter.** `sq_cnt`, 3 bits.
  - When `stall`=0 and `jmp_taken`=1: load `SQUASH_CYCLES`-1.
  - Else, when `stall`=0 and `sq_cnt`≠0: decrement.
  - `jmp_active` = (`jmp_taken` & ~`stall`) | (`sq_cnt`≠0).
- **Outputs** (combinational from state and inputs):
  - `stall` = `mem_busy`.
  - `squash` = `jmp_active` | `raw`.
  - `hold_fetch` = `raw` & ~`jmp_active`. On a jump, fetch is redirected rather than held.
- **Latency.** A RAW stall lasts until the producer leaves `sb[WB_DEPTH-1]`. A producer immediately ahead gives `WB_DEPTH` bubble cycles; the consumer issues on the next cycle.
- **Simultaneous events.**
  - `jmp_taken` + `raw`: jump wins. Squash, no hold, and the counter loads.
  - `jmp_taken` while `stall`=1: ignored. The source holds `jmp_taken` because execute is frozen.
  - `jmp_taken` while `sq_cnt`≠0: counter reloads.
- **Boundary.** Duplicate destinations in the scoreboard are legal. Any match hazards.
- **Reset** (`rst`=0, asynchronous):
  - All `sb` entries = 0, `sq_cnt` = 0.
  - `squash` forced 1, `hold_fetch` forced 0, `stall` forced 0.
  - Deassertion takes effect at the next rising edge. Reset mid-hazard discards all tracked state.

Optional Feature:
- Macro `HAZARD_PERF_CNT_EN`.
- **Defined:**
  - Adds outputs `raw_bubble_cnt` [`CNT_W`] and `jmp_bubble_cnt` [`CNT_W`].
  - `raw_bubble_cnt` increments each non-stalled cycle with `raw` & ~`jmp_active`.
  - `jmp_bubble_cnt` increments each non-stalled cycle with `jmp_active`.
  - Counters saturate at all-ones and reset to 0.
- **Undefined:** the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `pipe_pkg`:
  - `REG_ADDR_W`=5, `REG_ZERO`=5'd0.
  - Default `WB_DEPTH`=3 and `SQUASH_CYCLES`=2.
  - The `ld_code` encodings, shared with decode/writeback.
- One sub-module, `hazard_scoreboard`:
  - Shift register plus comparators.
  - Inputs: `clk`, `rst`, `shift_en`, `dst_in`, `a0`, `a1`, `rs1_used`, `rs2_used`.
  - Output: `raw`.
- The top holds the squash counter, output logic and optional counters.

Test Plan:
- Reset with `rst`=0 for 2 cycles, `jmp_taken`=1, `a0`=5 → `squash`=1, `hold_fetch`=0, `stall`=0. After release with idle inputs → all outputs 0.
- Issue `a2_hazard`=7, then the next instruction with `a0`=7, `rs1_used`=1 → `hold_fetch`=1 and `squash`=1 for exactly 3 cycles, then 0. Same sequence with `a0`=0 or `rs1_used`=0 → no hazard.
- `jmp_taken`=1 pulse for one cycle → `squash`=1 for exactly 2 cycles, `hold_fetch`=0 throughout. Same pulse while `raw`=1 → `hold_fetch`=0, `squash` for 2 cycles, and the scoreboard receives 0 entries.
- `raw` active with 2 cycles remaining, `mem_busy`=1 for 4 cycles → `stall`=1 and the scoreboard is frozen. After release, `hold_fetch` persists exactly 2 more cycles.
- Back-to-back destinations 3, 3, 9, then `a1`=3 with `rs2_used`=1 → `hold_fetch` until both 3s have retired (3 cycles after the last 3 issued).
- With `HAZARD_PERF_CNT_EN` defined, run the RAW scenario then the jump scenario → `raw_bubble_cnt`=3, `jmp_bubble_cnt`=2. A preload near saturation stays at all-ones.
